// File: rtl/frv_mem_responder.sv
// Target-side responder for a req/gnt memory port: programmable wait states,
// byte-strobed writes into a word array, and a one-cycle-later read/error response.
module frv_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        mem_req,
  input  logic        mem_wen,
  input  logic [3:0]  mem_strb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  input  logic        stall,
  output logic        mem_gnt,
  output logic        mem_error,
  output logic [31:0] mem_rdata
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WAIT_MAX = 4'(WAIT_CYCLES);
  localparam logic [32:0] BASE_EXT = {1'b0, BASE_ADDR};
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;

  logic [3:0]       wcnt;
  logic [3:0]       wcnt_nxt;
  logic [32:0]      off;
  logic             in_range;
  logic             aligned;
  logic             fault;
  logic [IDX_W-1:0] idx;
  logic [31:0]      mem [DEPTH_WORDS];

  // 33-bit decode so addresses below the base cannot wrap into range
  assign off      = {1'b0, mem_addr} - BASE_EXT;
  assign in_range = ({1'b0, mem_addr} >= BASE_EXT) && (off < SPAN);
  assign aligned  = (mem_addr[1:0] == 2'b00);
  assign fault    = !(in_range && aligned);
  assign idx      = off[IDX_W+1:2];

  // Grant is combinational so zero wait states grant in the request cycle
  assign mem_gnt = g_resetn && mem_req && !stall && (wcnt == WAIT_MAX);

  // Wait counter: clears on accept or withdrawal, freezes under stall
  always_comb begin
    wcnt_nxt = wcnt;
    if (!mem_req || mem_gnt) begin
      wcnt_nxt = '0;
    end else if (!stall && (wcnt != WAIT_MAX)) begin
      wcnt_nxt = wcnt + 4'd1;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      wcnt      <= '0;
      mem_error <= 1'b0;
      mem_rdata <= '0;
    end else begin
      wcnt      <= wcnt_nxt;
      mem_error <= mem_gnt && fault;
      if (mem_gnt) begin
        mem_rdata <= (fault || mem_wen) ? 32'h0 : mem[idx];
      end
    end
  end

  // Storage is deliberately not reset; contents survive g_resetn
  always_ff @(posedge g_clk) begin
    if (mem_gnt && !fault && mem_wen) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_strb[i]) begin
          mem[idx][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_frv_mem_responder.sv
// Bench for frv_mem_responder: randomized traffic against a word-array model on a
// zero-wait instance, plus directed wait/stall/reset sequences on wait-2 and wait-3 instances.
module tb_frv_mem_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;
  localparam int          W0    = 0;

  logic g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  int checks = 0;
  int errors = 0;

  // zero-wait instance (model checked)
  logic        rst0 = 1'b1;
  logic        req0 = 1'b0, wen0 = 1'b0, stall0 = 1'b0;
  logic [3:0]  strb0 = 4'h0;
  logic [31:0] wdata0 = 32'h0, addr0 = 32'h0;
  logic        gnt0, err0;
  logic [31:0] rdata0;

  // wait-2 instance
  logic        req2 = 1'b0, wen2 = 1'b0, stall2 = 1'b0;
  logic [3:0]  strb2 = 4'hF;
  logic [31:0] wdata2 = 32'h0, addr2 = 32'h0;
  logic        gnt2, err2;
  logic [31:0] rdata2;

  // wait-3 instance
  logic        rst3 = 1'b1;
  logic        req3 = 1'b0, wen3 = 1'b0;
  logic [3:0]  strb3 = 4'hF;
  logic [31:0] wdata3 = 32'h0, addr3 = 32'h0;
  logic        gnt3, err3;
  logic [31:0] rdata3;

  frv_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W0)) u0 (
    .g_clk(g_clk), .g_resetn(rst0), .mem_req(req0), .mem_wen(wen0), .mem_strb(strb0),
    .mem_wdata(wdata0), .mem_addr(addr0), .stall(stall0),
    .mem_gnt(gnt0), .mem_error(err0), .mem_rdata(rdata0));

  frv_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u2 (
    .g_clk(g_clk), .g_resetn(rst0), .mem_req(req2), .mem_wen(wen2), .mem_strb(strb2),
    .mem_wdata(wdata2), .mem_addr(addr2), .stall(stall2),
    .mem_gnt(gnt2), .mem_error(err2), .mem_rdata(rdata2));

  frv_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) u3 (
    .g_clk(g_clk), .g_resetn(rst3), .mem_req(req3), .mem_wen(wen3), .mem_strb(strb3),
    .mem_wdata(wdata3), .mem_addr(addr3), .stall(1'b0),
    .mem_gnt(gnt3), .mem_error(err3), .mem_rdata(rdata3));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model of u0 ----------------
  logic [31:0] mdl [DEPTH];
  int          m_cnt   = 0;
  logic [31:0] exp_rd  = 32'h0;
  logic        exp_err = 1'b0;
  wire         m_gnt   = rst0 && req0 && !stall0 && (m_cnt == W0);

  function automatic bit is_fault(input logic [31:0] a);
    longint unsigned la = {32'h0, a};
    return !(la >= 64'(BASE) && (la - 64'(BASE)) < 64'(4 * DEPTH) && (la % 4) == 0);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'(({32'h0, a} - 64'(BASE)) / 4);
  endfunction

  always @(posedge g_clk or negedge rst0) begin
    if (!rst0) begin
      m_cnt   <= 0;
      exp_rd  <= 32'h0;
      exp_err <= 1'b0;
    end else if (m_gnt) begin
      m_cnt <= 0;
      if (is_fault(addr0)) begin
        exp_err <= 1'b1;
        exp_rd  <= 32'h0;
      end else begin
        exp_err <= 1'b0;
        if (wen0) begin
          exp_rd <= 32'h0;
          for (int b = 0; b < 4; b++)
            if (strb0[b]) mdl[word_of(addr0)][8*b +: 8] <= wdata0[8*b +: 8];
        end else begin
          exp_rd <= mdl[word_of(addr0)];
        end
      end
    end else begin
      exp_err <= 1'b0;
      if (!req0) m_cnt <= 0;
      else if (!stall0 && m_cnt < W0) m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge g_clk) begin
    chk("u0_gnt", 32'(gnt0), 32'(m_gnt));
    chk("u0_error", 32'(err0), 32'(exp_err));
    chk("u0_rdata", rdata0, exp_rd);
  end

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge g_clk);
      #1;
    end
  endtask

  // Issue one u0 request and hold it until granted; returns in the response cycle.
  task automatic do0(input logic w, input logic [3:0] s, input logic [31:0] d,
                     input logic [31:0] a, input bit rs, output int lat);
    bit done = 1'b0;
    lat    = 0;
    req0   = 1'b1;
    wen0   = w;
    strb0  = s;
    wdata0 = d;
    addr0  = a;
    stall0 = rs && ($urandom_range(0, 2) == 0);
    while (!done && lat < 64) begin
      @(negedge g_clk);
      if (gnt0) done = 1'b1;
      @(posedge g_clk);
      #1;
      if (!done) begin
        lat++;
        stall0 = rs && ($urandom_range(0, 2) == 0);
      end
    end
    req0   = 1'b0;
    stall0 = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL u0_gnt_timeout: no grant after %0d cycles, grant required", lat);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5, 6: return BASE + 32'(4 * $urandom_range(0, 31));
      7:                   return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      8:                   return BASE + 32'($urandom_range(0, 127));
      default: begin
        case ($urandom_range(0, 4))
          0:       return 32'h7FFF_FFFC;
          1:       return 32'h8000_1000;
          2:       return 32'h8000_0FFC;
          3:       return 32'hFFFF_FFFC;
          default: return 32'h0000_0000;
        endcase
      end
    endcase
  endfunction

  // One u2 sequence of 7 cycles; bit k of each vector belongs to cycle k
  task automatic run2(input string nm, input logic [31:0] a, input logic w,
                      input logic [6:0] rq, input logic [6:0] st,
                      input logic [6:0] gn, input logic [6:0] er);
    addr2  = a;
    wen2   = w;
    wdata2 = 32'h0BAD_F00D;
    for (int k = 0; k < 7; k++) begin
      @(posedge g_clk);
      #1;
      req2   = rq[k];
      stall2 = st[k];
      @(negedge g_clk);
      chk($sformatf("%s_gnt_c%0d", nm, k), 32'(gnt2), 32'(gn[k]));
      chk($sformatf("%s_err_c%0d", nm, k), 32'(err2), 32'(er[k]));
    end
  endtask

  task automatic cyc3(input string nm, input logic rq, input logic rs,
                      input logic eg, input logic ee);
    @(posedge g_clk);
    #1;
    req3 = rq;
    rst3 = rs;
    @(negedge g_clk);
    chk({nm, "_gnt"}, 32'(gnt3), 32'(eg));
    chk({nm, "_err"}, 32'(err3), 32'(ee));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    #2;
    rst0  = 1'b0;
    rst3  = 1'b0;
    req0  = 1'b1;
    addr0 = 32'h8000_0010;
    repeat (3) begin
      @(negedge g_clk);
      chk("rst_gnt", 32'(gnt0), 32'h0);
      chk("rst_err", 32'(err0), 32'h0);
      chk("rst_rdata", rdata0, 32'h0);
    end
    @(posedge g_clk);
    #1;
    req0 = 1'b0;
    rst0 = 1'b1;
    rst3 = 1'b1;
    idle(1);

    do0(1'b1, 4'hF, 32'hDEAD_BEEF, 32'h8000_0010, 1'b0, lat);
    chk("wr_latency", 32'(lat), 32'h0);
    do0(1'b0, 4'hF, 32'h0, 32'h8000_0010, 1'b0, lat);
    chk("rd_latency", 32'(lat), 32'h0);
    chk("rd_deadbeef", rdata0, 32'hDEAD_BEEF);
    chk("rd_deadbeef_err", 32'(err0), 32'h0);

    for (int i = 0; i < DEPTH; i++)
      do0(1'b1, 4'hF, $urandom, BASE + 32'(4 * i), 1'b0, lat);

    repeat (1500) begin
      do0(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, rand_addr(), 1'b1, lat);
      if ($urandom_range(0, 3) == 0) idle(1);
    end

    do0(1'b1, 4'hF, 32'h1122_3344, 32'h8000_0020, 1'b0, lat);
    do0(1'b1, 4'b0101, 32'hAABB_CCDD, 32'h8000_0020, 1'b0, lat);
    do0(1'b0, 4'h0, 32'h0, 32'h8000_0020, 1'b0, lat);
    chk("strb_merge", rdata0, 32'h11BB_33DD);

    do0(1'b0, 4'h0, 32'h0, 32'h8000_1000, 1'b0, lat);
    chk("oor_err", 32'(err0), 32'h1);
    chk("oor_rdata", rdata0, 32'h0);
    idle(1);
    chk("oor_err_drop", 32'(err0), 32'h0);
    do0(1'b0, 4'h0, 32'h0, 32'h8000_0FFC, 1'b0, lat);
    chk("last_word_err", 32'(err0), 32'h0);
    do0(1'b0, 4'h0, 32'h0, 32'h8000_0002, 1'b0, lat);
    chk("misalign_err", 32'(err0), 32'h1);
    do0(1'b1, 4'hF, 32'h5A5A_5A5A, 32'h7FFF_FFFC, 1'b0, lat);
    chk("below_base_err", 32'(err0), 32'h1);
    do0(1'b1, 4'hF, 32'hA5A5_A5A5, 32'h8000_1000, 1'b0, lat);
    for (int i = 0; i < DEPTH; i++)
      do0(1'b0, 4'h0, 32'h0, BASE + 32'(4 * i), 1'b0, lat);
    idle(1);

    // wait 2: one stalled counting cycle, then stall exactly at the grant point
    run2("w2a", 32'h8000_0040, 1'b1, 7'b0001111, 7'b0000010, 7'b0001000, 7'b0000000);
    run2("w2b", 32'h8000_0002, 1'b0, 7'b0011111, 7'b0001100, 7'b0010000, 7'b0100000);
    chk("w2b_rdata", rdata2, 32'h0);

    // wait 3: reset while counting, grant three cycles after release
    addr3 = 32'h8000_0002;
    wen3  = 1'b0;
    cyc3("mw0", 1'b1, 1'b1, 1'b0, 1'b0);
    cyc3("mw1", 1'b1, 1'b1, 1'b0, 1'b0);
    cyc3("mw2", 1'b1, 1'b0, 1'b0, 1'b0);
    cyc3("mw3", 1'b1, 1'b0, 1'b0, 1'b0);
    cyc3("rel0", 1'b1, 1'b1, 1'b0, 1'b0);
    cyc3("rel1", 1'b1, 1'b1, 1'b0, 1'b0);
    cyc3("rel2", 1'b1, 1'b1, 1'b0, 1'b0);
    cyc3("rel3", 1'b1, 1'b1, 1'b1, 1'b0);
    cyc3("rel_resp", 1'b0, 1'b1, 1'b0, 1'b1);
    cyc3("rel_post", 1'b0, 1'b1, 1'b0, 1'b0);

    // wait 3: write then read, reset lands in the read's response cycle
    addr3  = 32'h8000_0000;
    wen3   = 1'b1;
    wdata3 = 32'h1234_5678;
    cyc3("wr0", 1'b1, 1'b1, 1'b0, 1'b0);
    cyc3("wr1", 1'b1, 1'b1, 1'b0, 1'b0);
    cyc3("wr2", 1'b1, 1'b1, 1'b0, 1'b0);
    cyc3("wr3", 1'b1, 1'b1, 1'b1, 1'b0);
    cyc3("wr_resp", 1'b0, 1'b1, 1'b0, 1'b0);
    wen3 = 1'b0;
    cyc3("rd0", 1'b1, 1'b1, 1'b0, 1'b0);
    cyc3("rd1", 1'b1, 1'b1, 1'b0, 1'b0);
    cyc3("rd2", 1'b1, 1'b1, 1'b0, 1'b0);
    cyc3("rd3", 1'b1, 1'b1, 1'b1, 1'b0);
    @(posedge g_clk);
    #1;
    req3 = 1'b0;
    chk("w3_rdata", rdata3, 32'h1234_5678);
    chk("w3_rd_err", 32'(err3), 32'h0);
    rst3 = 1'b0;
    #1;
    chk("resp_rst_rdata", rdata3, 32'h0);
    chk("resp_rst_err", 32'(err3), 32'h0);
    cyc3("no_replay", 1'b0, 1'b1, 1'b0, 1'b0);

    // wait 3: withdrawn request is dropped and counting restarts
    addr3 = 32'h8000_0006;
    cyc3("wd0", 1'b1, 1'b1, 1'b0, 1'b0);
    cyc3("wd1", 1'b1, 1'b1, 1'b0, 1'b0);
    cyc3("wd2", 1'b0, 1'b1, 1'b0, 1'b0);
    cyc3("wd3", 1'b0, 1'b1, 1'b0, 1'b0);
    cyc3("wd4", 1'b0, 1'b1, 1'b0, 1'b0);
    cyc3("nr0", 1'b1, 1'b1, 1'b0, 1'b0);
    cyc3("nr1", 1'b1, 1'b1, 1'b0, 1'b0);
    cyc3("nr2", 1'b1, 1'b1, 1'b0, 1'b0);
    cyc3("nr3", 1'b1, 1'b1, 1'b1, 1'b0);
    cyc3("nr_resp", 1'b0, 1'b1, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
